// File: rtl/mrd_mem_pkt.sv
// Shared constants and types for the mixed-radix DFT memory banks.
package mrd_mem_pkt;

    localparam int unsigned wADDR     = 10;
    localparam int unsigned NUM_BANKS = 7;
    localparam int unsigned NUM_LANES = 5;
    localparam logic [2:0]  INVALID_BANK = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } wr_state_t;

endpackage

// File: rtl/mrd_tag_fifo.sv
// Synchronous tag FIFO with wrap-bit pointers, full/empty flags and flush.
module mrd_tag_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_flush;
    assign o_dout    = r_mem[r_rp[AW-1:0]];

    // Pointer update; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop_ok)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mrd_fsmwr_wrback.sv
// Write-back engine: tag FIFO across core latency, bank steering, stage FSM.
module mrd_fsmwr_wrback #(
    parameter int unsigned wADDR     = mrd_mem_pkt::wADDR,
    parameter int unsigned wDATA     = 18,
    parameter int unsigned TAG_DEPTH = 32,
    parameter int unsigned wCNT      = 12
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          stage_start,
    input  logic [wCNT-1:0]                               cnt_wr_stop,
    input  logic                                          tag_valid,
    input  logic [mrd_mem_pkt::NUM_LANES-1:0][2:0]        tag_bank_index,
    input  logic [mrd_mem_pkt::NUM_LANES-1:0][wADDR-1:0]  tag_bank_addr,
    input  logic                                          dat_valid,
    input  logic [mrd_mem_pkt::NUM_LANES-1:0][wDATA-1:0]  dat_real,
    input  logic [mrd_mem_pkt::NUM_LANES-1:0][wDATA-1:0]  dat_imag,
    output logic [mrd_mem_pkt::NUM_BANKS-1:0]             wren,
    output logic [mrd_mem_pkt::NUM_BANKS-1:0][wADDR-1:0]  wraddr,
    output logic [mrd_mem_pkt::NUM_BANKS-1:0][wDATA-1:0]  wrdata_real,
    output logic [mrd_mem_pkt::NUM_BANKS-1:0][wDATA-1:0]  wrdata_imag,
    output logic                                          wr_busy,
    output logic                                          wr_end,
    output logic                                          err_overflow,
    output logic                                          err_underflow,
    output logic                                          err_conflict,
    input  logic                                          err_clr
);

    import mrd_mem_pkt::*;

    localparam int unsigned TAG_W = NUM_LANES * (3 + wADDR);

    wr_state_t                             r_state;
    logic [wCNT-1:0]                       r_cnt;
    logic [wCNT-1:0]                       r_stop;
    logic [TAG_W-1:0]                      w_din;
    logic [TAG_W-1:0]                      w_dout;
    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_pop;
    logic                                  w_push;
    logic [NUM_LANES-1:0][2:0]             w_idx;
    logic [NUM_LANES-1:0][wADDR-1:0]       w_addr;
    logic [NUM_BANKS-1:0]                  w_wren;
    logic [NUM_BANKS-1:0][wADDR-1:0]       w_wraddr;
    logic [NUM_BANKS-1:0][wDATA-1:0]       w_re;
    logic [NUM_BANKS-1:0][wDATA-1:0]       w_im;
    logic                                  w_conf;

    assign w_din          = {tag_bank_index, tag_bank_addr};
    assign {w_idx, w_addr} = w_dout;
    // No bypass: a result only pops a tag that is already stored.
    assign w_pop          = dat_valid && !w_empty && !stage_start;
    assign w_push         = tag_valid && !stage_start;
    assign wr_busy        = (r_state != ST_IDLE);
    assign wr_end         = (r_state == ST_DONE);

    mrd_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (stage_start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Lane-to-bank crossbar; the lowest lane claiming a bank wins.
    always_comb begin
        w_wren   = '0;
        w_wraddr = '0;
        w_re     = '0;
        w_im     = '0;
        w_conf   = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                if (w_idx[k] != INVALID_BANK && w_idx[k] == 3'(b)) begin
                    if (w_wren[b]) begin
                        w_conf = 1'b1;
                    end else begin
                        w_wren[b]   = 1'b1;
                        w_wraddr[b] = w_addr[k];
                        w_re[b]     = dat_real[k];
                        w_im[b]     = dat_imag[k];
                    end
                end
            end
        end
    end

    // Stage FSM, butterfly counter and registered bank write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_stop      <= '0;
            wren        <= '0;
            wraddr      <= '0;
            wrdata_real <= '0;
            wrdata_imag <= '0;
        end else begin
            wren        <= w_pop ? w_wren   : '0;
            wraddr      <= w_pop ? w_wraddr : '0;
            wrdata_real <= w_pop ? w_re     : '0;
            wrdata_imag <= w_pop ? w_im     : '0;
            if (stage_start) begin
                r_state <= ST_ACTIVE;
                r_cnt   <= '0;
                r_stop  <= cnt_wr_stop;
            end else begin
                case (r_state)
                    ST_ACTIVE: begin
                        if (w_pop) begin
                            if (r_cnt != r_stop) r_cnt <= r_cnt + wCNT'(1);
                            if (r_cnt + wCNT'(1) == r_stop) r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_conflict  <= 1'b0;
        end else if (err_clr) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_conflict  <= 1'b0;
        end else begin
            if (tag_valid && w_full && !dat_valid && !stage_start) err_overflow <= 1'b1;
            if (dat_valid && w_empty) err_underflow <= 1'b1;
            if (w_pop && w_conf) err_conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mrd_fsmwr_wrback.sv
// Directed bench with a tag model and a write scoreboard for mrd_fsmwr_wrback.
module tb_mrd_fsmwr_wrback;

    import mrd_mem_pkt::*;

    localparam int unsigned AW = mrd_mem_pkt::wADDR;
    localparam int unsigned DW = 18;
    localparam int unsigned CW = 12;

    typedef struct packed {
        logic [4:0][2:0]    idx;
        logic [4:0][AW-1:0] ad;
    } tag_t;

    typedef struct packed {
        logic [6:0]         wren;
        logic [6:0][AW-1:0] addr;
        logic [6:0][DW-1:0] re;
        logic [6:0][DW-1:0] im;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stage_start;
    logic [CW-1:0]       cnt_wr_stop;
    logic                tag_valid;
    logic [4:0][2:0]     tag_bank_index;
    logic [4:0][AW-1:0]  tag_bank_addr;
    logic                dat_valid;
    logic [4:0][DW-1:0]  dat_real;
    logic [4:0][DW-1:0]  dat_imag;
    logic [6:0]          wren;
    logic [6:0][AW-1:0]  wraddr;
    logic [6:0][DW-1:0]  wrdata_real;
    logic [6:0][DW-1:0]  wrdata_imag;
    logic                wr_busy;
    logic                wr_end;
    logic                err_overflow;
    logic                err_underflow;
    logic                err_conflict;
    logic                err_clr;

    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;
    tag_t tq[$];
    exp_t sb[$];

    mrd_fsmwr_wrback dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stage_start    (stage_start),
        .cnt_wr_stop    (cnt_wr_stop),
        .tag_valid      (tag_valid),
        .tag_bank_index (tag_bank_index),
        .tag_bank_addr  (tag_bank_addr),
        .dat_valid      (dat_valid),
        .dat_real       (dat_real),
        .dat_imag       (dat_imag),
        .wren           (wren),
        .wraddr         (wraddr),
        .wrdata_real    (wrdata_real),
        .wrdata_imag    (wrdata_imag),
        .wr_busy        (wr_busy),
        .wr_end         (wr_end),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .err_conflict   (err_conflict),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dre(input int s, input int k);
        return DW'(s * 16 + k + 1);
    endfunction

    function automatic logic [DW-1:0] dim(input int s, input int k);
        return DW'(s * 16 + k + 'h10000);
    endfunction

    function automatic logic [4:0][2:0] mk_idx(input int a0, a1, a2, a3, a4);
        logic [4:0][2:0] v;
        v[0] = 3'(a0); v[1] = 3'(a1); v[2] = 3'(a2); v[3] = 3'(a3); v[4] = 3'(a4);
        return v;
    endfunction

    function automatic logic [4:0][AW-1:0] mk_ad(input int a0, a1, a2, a3, a4);
        logic [4:0][AW-1:0] v;
        v[0] = AW'(a0); v[1] = AW'(a1); v[2] = AW'(a2); v[3] = AW'(a3); v[4] = AW'(a4);
        return v;
    endfunction

    // Reference bank write for one popped tag: first lane naming a bank owns it.
    function automatic exp_t model(input tag_t t, input int s);
        exp_t e;
        e = '0;
        for (int k = 0; k < 5; k++) begin
            if (t.idx[k] < 3'd7 && !e.wren[t.idx[k]]) begin
                e.wren[t.idx[k]] = 1'b1;
                e.addr[t.idx[k]] = t.ad[k];
                e.re[t.idx[k]]   = dre(s, k);
                e.im[t.idx[k]]   = dim(s, k);
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stage(input int n);
        stage_start = 1'b1;
        cnt_wr_stop = CW'(n);
        tq.delete();
        tick();
        stage_start = 1'b0;
    endtask

    task automatic push_tag(input logic [4:0][2:0] idx, input logic [4:0][AW-1:0] ad);
        tag_t t;
        t.idx = idx;
        t.ad  = ad;
        tag_valid      = 1'b1;
        tag_bank_index = idx;
        tag_bank_addr  = ad;
        if (tq.size() < 32) tq.push_back(t);
        tick();
        tag_valid = 1'b0;
    endtask

    task automatic send_dat();
        tag_t t;
        dat_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dat_real[k] = dre(seq, k);
            dat_imag[k] = dim(seq, k);
        end
        if (tq.size() > 0) begin
            t = tq.pop_front();
            sb.push_back(model(t, seq));
        end
        tick();
        dat_valid = 1'b0;
        seq++;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Scoreboard: every non-empty bank write must match the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wren !== 7'd0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 128'(wren), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_wren",   128'(wren),        128'(e.wren));
                chk("sb_wraddr", 128'(wraddr),      128'(e.addr));
                chk("sb_real",   128'(wrdata_real), 128'(e.re));
                chk("sb_imag",   128'(wrdata_imag), 128'(e.im));
            end
        end
    end

    initial begin
        rst_n = 1'b0; stage_start = 1'b0; cnt_wr_stop = '0; tag_valid = 1'b0;
        tag_bank_index = '1; tag_bank_addr = '0; dat_valid = 1'b0;
        dat_real = '0; dat_imag = '0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_wren",  128'(wren), 128'(0));
        chk("rst_busy",  128'(wr_busy), 128'(0));
        chk("rst_end",   128'(wr_end), 128'(0));
        chk("rst_errs",  128'({err_overflow, err_underflow, err_conflict}), 128'(0));
        rst_n = 1'b1;
        tick();

        // Radix-5 stage of three butterflies.
        start_stage(3);
        chk("r5_busy", 128'(wr_busy), 128'(1));
        for (int i = 0; i < 3; i++) push_tag(mk_idx(0, 1, 2, 3, 4), mk_ad(10, 11, 12, 13, 14));
        for (int i = 0; i < 4; i++) tick();
        send_dat();
        chk("r5_end1", 128'(wr_end), 128'(0));
        send_dat();
        chk("r5_end2", 128'(wr_end), 128'(0));
        send_dat();
        chk("r5_end3",  128'(wr_end), 128'(1));
        chk("r5_wren",  128'(wren), 128'(7'b0011111));
        chk("r5_addr3", 128'(wraddr[3]), 128'(13));
        chk("r5_dat3",  128'(wrdata_real[3]), 128'(dre(seq - 1, 3)));
        tick();
        chk("r5_busy_drop", 128'(wr_busy), 128'(0));
        chk("r5_end_drop",  128'(wr_end), 128'(0));

        // Radix-3 stage: lanes 3,4 unused.
        start_stage(1);
        push_tag(mk_idx(6, 5, 4, 7, 7), mk_ad(1, 2, 3, 0, 0));
        send_dat();
        chk("r3_wren",  128'(wren), 128'(7'b1110000));
        chk("r3_addr6", 128'(wraddr[6]), 128'(1));
        chk("r3_addr4", 128'(wraddr[4]), 128'(3));
        chk("r3_low",   128'({wraddr[3], wraddr[2], wraddr[1], wraddr[0]}), 128'(0));
        chk("r3_end",   128'(wr_end), 128'(1));
        tick();

        // Two lanes on bank 2: lane 0 wins, conflict flag sticks.
        start_stage(1);
        push_tag(mk_idx(2, 2, 7, 7, 7), mk_ad(5, 9, 0, 0, 0));
        send_dat();
        chk("cf_wren",  128'(wren), 128'(7'b0000100));
        chk("cf_addr2", 128'(wraddr[2]), 128'(5));
        chk("cf_dat2",  128'(wrdata_real[2]), 128'(dre(seq - 1, 0)));
        chk("cf_err",   128'(err_conflict), 128'(1));
        tick(); tick();
        chk("cf_hold",  128'(err_conflict), 128'(1));
        clear_errs();
        chk("cf_clr",   128'(err_conflict), 128'(0));

        // Underflow, then overflow with 33 pushes and an in-order drain.
        send_dat();
        chk("uf_wren", 128'(wren), 128'(0));
        chk("uf_err",  128'(err_underflow), 128'(1));
        clear_errs();
        for (int i = 0; i < 32; i++) push_tag(mk_idx(0, 1, 2, 3, 4), mk_ad(i*8, i*8+1, i*8+2, i*8+3, i*8+4));
        chk("of_err32", 128'(err_overflow), 128'(0));
        push_tag(mk_idx(6, 6, 6, 6, 6), mk_ad(999, 0, 0, 0, 0));
        chk("of_err33", 128'(err_overflow), 128'(1));
        for (int i = 0; i < 32; i++) send_dat();
        tick();
        chk("of_drained", 128'(sb.size()), 128'(0));
        chk("of_uf_clean", 128'(err_underflow), 128'(0));
        send_dat();
        chk("of_uf_after", 128'(err_underflow), 128'(1));
        clear_errs();

        // Restart a stage mid-way.
        start_stage(5);
        for (int i = 0; i < 5; i++) push_tag(mk_idx(0, 1, 7, 7, 7), mk_ad(i, i+100, 0, 0, 0));
        send_dat();
        send_dat();
        chk("rs_end_old", 128'(wr_end), 128'(0));
        start_stage(1);
        chk("rs_end_start", 128'(wr_end), 128'(0));
        chk("rs_busy", 128'(wr_busy), 128'(1));
        send_dat();
        chk("rs_flushed_wren", 128'(wren), 128'(0));
        chk("rs_flushed_uf",   128'(err_underflow), 128'(1));
        chk("rs_end_none",     128'(wr_end), 128'(0));
        clear_errs();
        push_tag(mk_idx(3, 4, 7, 7, 7), mk_ad(40, 41, 0, 0, 0));
        send_dat();
        chk("rs_end_new", 128'(wr_end), 128'(1));
        tick();

        // Asynchronous reset between clock edges while a write is showing.
        start_stage(2);
        push_tag(mk_idx(1, 1, 7, 7, 7), mk_ad(7, 8, 0, 0, 0));
        push_tag(mk_idx(0, 1, 2, 3, 4), mk_ad(20, 21, 22, 23, 24));
        send_dat();
        @(negedge clk);
        #1;
        chk("ar_pre_busy", 128'(wr_busy), 128'(1));
        chk("ar_pre_conf", 128'(err_conflict), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("ar_wren", 128'(wren), 128'(0));
        chk("ar_busy", 128'(wr_busy), 128'(0));
        chk("ar_end",  128'(wr_end), 128'(0));
        chk("ar_errs", 128'({err_overflow, err_underflow, err_conflict}), 128'(0));
        tq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle", 128'({wr_busy, wr_end, wren}), 128'(0));
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mrd_fsmwr_wrback.md
Name: mrd_fsmwr_wrback

Overview:
- Write-back side of the mixed-radix DFT memory; the counterpart of the stage read engine.
- Captures the per-lane bank index and bank address tags the read engine emits with each butterfly read. Holds them in a tag FIFO across the rdx2345 core latency.
- When the core's result arrives, pops one tag and writes up to 5 results into the 7 dual-port banks (in-place update).
- Counts butterflies per stage and pulses wr_end when the stage's last write is issued.

Parameters:
- wADDR, mrd_mem_pkt::wADDR, bank address width
- wDATA, 18, real/imag sample width
- TAG_DEPTH, 32, tag FIFO entries (power of 2, >= core latency + 2)
- wCNT, 12, butterfly counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stage_start  in  1  pulse: new stage begins; flushes FIFO, loads cnt_wr_stop
- cnt_wr_stop  in  wCNT  butterflies in this stage (>=1), sampled on stage_start
- tag_valid  in  1  read-side tag strobe (read engine's output valid)
- tag_bank_index  in  5x3  per-lane bank 0..6; 7 = lane unused
- tag_bank_addr  in  5xwADDR  per-lane word address
- dat_valid  in  1  core result strobe
- dat_real, dat_imag  in  5xwDATA  per-lane results
- wren  out  7  per-bank write enable
- wraddr  out  7xwADDR  per-bank write address
- wrdata_real, wrdata_imag  out  7xwDATA  per-bank write data
- wr_busy  out  1  state != IDLE
- wr_end  out  1  one-cycle pulse after the final write of the stage
- err_overflow, err_underflow, err_conflict  out  1 each  sticky error flags
- err_clr  in  1  clears the sticky error flags

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, counter 0, state IDLE.
- States:
  - IDLE --stage_start--> ACTIVE
  - ACTIVE --(write count == cnt_wr_stop)--> DONE
  - DONE --1 cycle--> IDLE; wr_end=1 only in DONE
  - stage_start in any state: flush FIFO, clear count, latch cnt_wr_stop, go ACTIVE. Sticky errors are unaffected.
- Tag FIFO:
  - Push on tag_valid; pop on dat_valid.
  - Push and pop in the same cycle are both legal when neither full nor empty; simultaneous push+pop when full is also legal.
  - No bypass: dat_valid with FIFO empty sets err_underflow, performs no write and leaves count unchanged, even if a push occurs in the same cycle.
  - tag_valid while full with no pop sets err_overflow; that tag is dropped.
  - Pointers are log2(TAG_DEPTH)+1 bits and wrap naturally.
- Write mapping (on pop in cycle N; outputs registered, visible in cycle N+1):
  - For each bank b in 0..6: wren[b]=1 if some lane k has index[k]==b; the lowest such k supplies wraddr[b] and wrdata[b].
  - Otherwise wren[b]=0, wraddr[b]=0, wrdata[b]=0.
  - Index 7 lanes are ignored.
  - Two or more valid lanes mapping to the same bank set err_conflict; the lowest lane still wins.
- Counting:
  - Every successful pop in ACTIVE increments the count, saturating at cnt_wr_stop.
  - The pop that reaches cnt_wr_stop moves the FSM to DONE, so wr_end appears in cycle N+1, coinciding with that final write.
  - dat_valid while in IDLE or DONE still pops and writes but is not counted.
- err_clr has priority over a same-cycle error set, i.e. the flag is cleared that cycle.
- wr_busy is combinational from the state register.

Decomposition:
- mrd_mem_pkt (shared package) holds:
  - wADDR and NUM_BANKS=7
  - INVALID_BANK=3'd7
  - the lane-count constant 5
  - the state typedef (IDLE, ACTIVE, DONE)
- Sub-module mrd_tag_fifo: synchronous FIFO, width 5*(3+wADDR), with full/empty outputs and a flush input. The bank-steering crossbar and FSM stay in the top level.

Test Plan:
- Radix-5 stage:
  - Stimulus: stage_start with cnt_wr_stop=3; three tags with indices {0,1,2,3,4}, addrs {10..14}; three dat_valid 4 cycles later.
  - Required: wren=7'b0011111 for 3 cycles; bank3 wraddr=13, carrying lane-3 data; wr_end coincides with the 3rd write; wr_busy drops the next cycle.
- Radix-3 stage:
  - Stimulus: indices {6,5,4,7,7}, addrs {1,2,3,x,x}.
  - Required: wren=7'b1110000 only; banks 0..3 remain 0.
- Conflict:
  - Stimulus: indices {2,2,7,7,7}, addrs {5,9}.
  - Required: bank2 wraddr=5 with lane-0 data; err_conflict=1 and held until err_clr.
- Underflow/overflow:
  - Stimulus: dat_valid with empty FIFO; then 33 tags pushed with no pops.
  - Required: no wren, err_underflow=1; 33rd tag dropped, err_overflow=1; 32 subsequent pops drain exactly the first 32 tags in order.
- Restart mid-stage:
  - Stimulus: after 2 of 5 writes, stage_start with cnt_wr_stop=1.
  - Required: FIFO empty, the old stage gives no wr_end, the new stage gives wr_end after 1 write.
- Async reset mid-write:
  - Stimulus: assert rst_n=0 mid-cycle during ACTIVE.
  - Required: wren, wr_busy, wr_end and errors go to 0 immediately without a clock edge.
